ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 149 ++++++++++++++
 tb/tb_ps2_host_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 8 data bits + odd parity, stop, ACK.
// Optional ACK checking is enabled with the macro PS2_HOST_TX_ACK_CHECK_EN.
module ps2_host_tx #(
   parameter int unsigned C_INHIBIT_CYCLES = 12000,
   parameter int unsigned C_TIMEOUT_CYCLES = 2000000
) (
   input  logic       iBusClk,
   input  logic       iRst,
   input  logic       iStart,
   input  logic [7:0] iData,
   output logic       oBusy,
   output logic       oDone,
   output logic       oErr,
   inout  wire        ps2clk,
   inout  wire        ps2data
);

   localparam int unsigned CNT_MAX = (C_INHIBIT_CYCLES > C_TIMEOUT_CYCLES) ?
                                     C_INHIBIT_CYCLES : C_TIMEOUT_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

`ifdef PS2_HOST_TX_ACK_CHECK_EN
   localparam bit ACK_CHECK = 1'b1;
`else
   localparam bit ACK_CHECK = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      INHIBIT = 3'd1,
      RTS     = 3'd2,
      SHIFT   = 3'd3,
      ACK     = 3'd4,
      FIN     = 3'd5
   } state_t;

   state_t           state;
   logic             clk_oe;
   logic             data_oe;
   logic [2:0]       clk_sync;
   logic [1:0]       data_sync;
   logic [8:0]       shreg;
   logic [3:0]       bit_cnt;
   logic [CNT_W-1:0] cnt;
   logic             clk_fall_c;

   // Open-drain drivers: an asserted enable pulls the line low, otherwise it floats.
   assign ps2clk  = clk_oe  ? 1'b0 : 1'bz;
   assign ps2data = data_oe ? 1'b0 : 1'bz;

   // clk_sync[1] is the synchronized level, clk_sync[2] its previous value.
   assign clk_fall_c = clk_sync[2] & ~clk_sync[1];

   always_ff @(posedge iBusClk) begin
      if (iRst) begin
         state     <= IDLE;
         clk_oe    <= 1'b0;
         data_oe   <= 1'b0;
         clk_sync  <= 3'b111;
         data_sync <= 2'b11;
         shreg     <= 9'd0;
         bit_cnt   <= 4'd0;
         cnt       <= CNT_W'(0);
         oBusy     <= 1'b0;
         oDone     <= 1'b0;
         oErr      <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[1:0], ps2clk};
         data_sync <= {data_sync[0], ps2data};
         oDone     <= 1'b0;
         oErr      <= 1'b0;

         unique case (state)
            IDLE: begin
               oBusy   <= 1'b0;
               clk_oe  <= 1'b0;
               data_oe <= 1'b0;
               if (iStart && !oBusy) begin
                  shreg   <= {~^iData, iData};
                  cnt     <= CNT_W'(0);
                  bit_cnt <= 4'd0;
                  clk_oe  <= 1'b1;
                  oBusy   <= 1'b1;
                  state   <= INHIBIT;
               end
            end

            INHIBIT: begin
               if (cnt == CNT_W'(C_INHIBIT_CYCLES - 1)) begin
                  cnt     <= CNT_W'(0);
                  clk_oe  <= 1'b0;
                  data_oe <= 1'b1;
                  state   <= RTS;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            RTS, SHIFT, ACK: begin
               // Timeout overrides any clock edge seen in the same cycle.
               if (cnt == CNT_W'(C_TIMEOUT_CYCLES - 1)) begin
                  clk_oe  <= 1'b0;
                  data_oe <= 1'b0;
                  oErr    <= 1'b1;
                  state   <= IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  if (state == RTS) begin
                     state <= SHIFT;
                  end else if (clk_fall_c) begin
                     bit_cnt <= (bit_cnt == 4'hF) ? bit_cnt : bit_cnt + 4'd1;
                     if (state == SHIFT) begin
                        if (bit_cnt == 4'd9) begin
                           data_oe <= 1'b0;
                           state   <= ACK;
                        end else begin
                           data_oe <= ~shreg[0];
                           shreg   <= {1'b0, shreg[8:1]};
                        end
                     end else begin
                        if (ACK_CHECK && data_sync[1]) begin
                           oErr <= 1'b1;
                        end else begin
                           oDone <= 1'b1;
                        end
                        state <= FIN;
                     end
                  end
               end
            end

            FIN: begin
               clk_oe  <= 1'b0;
               data_oe <= 1'b0;
               oBusy   <= 1'b0;
               state   <= IDLE;
            end

            default: begin
               clk_oe  <= 1'b0;
               data_oe <= 1'b0;
               oBusy   <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model clocks frames and a scoreboard checks bytes and results.
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int unsigned INH  = 120;
   localparam int unsigned TMO  = 2000;
   localparam int unsigned HALF = 40;

`ifdef PS2_HOST_TX_ACK_CHECK_EN
   localparam bit ACK_CHK = 1'b1;
`else
   localparam bit ACK_CHK = 1'b0;
`endif

   typedef struct {
      logic [7:0] byte_v;
      logic       exp_err;
   } exp_t;

   exp_t sb[$];

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       start = 1'b0;
   logic [7:0] data  = 8'd0;
   logic       busy;
   logic       done;
   logic       err;
   wire        ps2clk_w;
   wire        ps2data_w;
   logic       dev_clk_low  = 1'b0;
   logic       dev_data_low = 1'b0;
   logic [9:0] frame;
   int         n_chk    = 0;
   int         n_pass   = 0;
   int         done_cnt = 0;
   int         err_cnt  = 0;

   pullup (ps2clk_w);
   pullup (ps2data_w);
   assign ps2clk_w  = dev_clk_low  ? 1'b0 : 1'bz;
   assign ps2data_w = dev_data_low ? 1'b0 : 1'bz;

   ps2_host_tx #(
      .C_INHIBIT_CYCLES(INH),
      .C_TIMEOUT_CYCLES(TMO)
   ) dut (
      .iBusClk (clk),
      .iRst    (rst),
      .iStart  (start),
      .iData   (data),
      .oBusy   (busy),
      .oDone   (done),
      .oErr    (err),
      .ps2clk  (ps2clk_w),
      .ps2data (ps2data_w)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Pulse monitor
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (err)  err_cnt++;
      if (done || err) check("pulse_exclusive", 32'(done & err), 32'd0);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic issue(input logic [7:0] b, input logic exp_err);
      data  = b;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      sb.push_back('{byte_v: b, exp_err: exp_err});
      check("busy_after_start", 32'(busy), 32'd1);
   endtask

   // Measure how long the host holds the clock low, then expect request-to-send.
   task automatic wait_rts();
      int len = 0;
      while (ps2clk_w === 1'b0 && len < int'(INH) + 200) begin
         len++;
         cyc(1);
      end
      check("inhibit_len", 32'(len), 32'(INH));
      check("rts_clk_released", 32'(ps2clk_w), 32'd1);
      check("rts_data_low", 32'(ps2data_w), 32'd0);
   endtask

   task automatic dev_clock(input int n_edges, input bit ack, input bit inject);
      frame = '0;
      for (int k = 1; k <= n_edges; k++) begin
         if (k == 11 && ack) dev_data_low = 1'b1;
         cyc(HALF);
         dev_clk_low = 1'b1;
         cyc(HALF);
         if (k <= 10) frame[k-1] = ps2data_w;
         dev_clk_low = 1'b0;
         if (k == 11) dev_data_low = 1'b0;
         if (inject && k == 3) begin
            data  = 8'h55;
            start = 1'b1;
            cyc(1);
            start = 1'b0;
            check("busy_during_ignored_start", 32'(busy), 32'd1);
         end
      end
   endtask

   task automatic wait_idle();
      int w = 0;
      while (busy === 1'b1 && w < 500) begin
         w++;
         cyc(1);
      end
      check("idle_reached", 32'(busy), 32'd0);
      cyc(2);
   endtask

   task automatic run_xfer(input logic [7:0] b, input bit ack, input bit inject);
      int   d0;
      int   e0;
      exp_t e;
      d0 = done_cnt;
      e0 = err_cnt;
      issue(b, ack ? 1'b0 : ACK_CHK);
      wait_rts();
      dev_clock(11, ack, inject);
      wait_idle();
      if (sb.size() == 0) begin
         check("scoreboard_underflow", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check("frame_byte", 32'(frame[7:0]), 32'(e.byte_v));
      check("frame_parity", 32'(frame[8]), 32'(~^e.byte_v));
      check("frame_stop", 32'(frame[9]), 32'd1);
      check("done_pulses", 32'(done_cnt - d0), e.exp_err ? 32'd0 : 32'd1);
      check("err_pulses", 32'(err_cnt - e0), e.exp_err ? 32'd1 : 32'd0);
      check("lines_idle_clk", 32'(ps2clk_w), 32'd1);
      check("lines_idle_data", 32'(ps2data_w), 32'd1);
   endtask

   initial begin
      int   c;
      int   d0;
      int   e0;
      exp_t e;

      // Reset state
      cyc(3);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_clk_z", 32'(ps2clk_w), 32'd1);
      check("rst_data_z", 32'(ps2data_w), 32'd1);
      rst = 1'b0;
      cyc(2);

      run_xfer(8'hF4, 1'b1, 1'b0);
      run_xfer(8'hFF, 1'b1, 1'b0);
      run_xfer(8'h00, 1'b0, 1'b0);

      // Device never clocks: timeout
      d0 = done_cnt;
      e0 = err_cnt;
      issue(8'h3C, 1'b1);
      wait_rts();
      c = 0;
      while (err !== 1'b1 && c < int'(TMO) + 100) begin
         cyc(1);
         c++;
      end
      check("tmo_latency", 32'(c), 32'(TMO));
      check("tmo_clk_z", 32'(ps2clk_w), 32'd1);
      check("tmo_data_z", 32'(ps2data_w), 32'd1);
      cyc(1);
      check("tmo_busy_clear", 32'(busy), 32'd0);
      cyc(2);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("tmo_err_pulses", 32'(err_cnt - e0), e.exp_err ? 32'd1 : 32'd0);
      end else begin
         check("scoreboard_underflow", 32'd0, 32'd1);
      end
      check("tmo_done_pulses", 32'(done_cnt - d0), 32'd0);

      // Reset after falling edge 5 of 0xAA
      d0 = done_cnt;
      e0 = err_cnt;
      issue(8'hAA, 1'b0);
      wait_rts();
      dev_clock(5, 1'b0, 1'b0);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      sb.delete();
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_clk_z", 32'(ps2clk_w), 32'd1);
      check("midrst_data_z", 32'(ps2data_w), 32'd1);
      cyc(300);
      check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
      check("midrst_no_err", 32'(err_cnt - e0), 32'd0);

      // Start coinciding with reset is dropped
      data  = 8'hF4;
      rst   = 1'b1;
      start = 1'b1;
      cyc(1);
      rst   = 1'b0;
      start = 1'b0;
      cyc(1);
      check("rst_start_busy", 32'(busy), 32'd0);
      cyc(20);
      check("rst_start_clk_z", 32'(ps2clk_w), 32'd1);

      run_xfer(8'hF4, 1'b1, 1'b0);

      // Second start during a transfer is not queued
      run_xfer(8'hF4, 1'b1, 1'b1);
      cyc(INH + 50);
      check("no_queued_clk", 32'(ps2clk_w), 32'd1);
      check("no_queued_busy", 32'(busy), 32'd0);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
